// File: rtl/data_mem_periph_if.sv
// Load/store bus between the execute stage and the data memory / peripheral block.
// The master drives the address and controls; the slave returns load data combinationally.
interface data_mem_periph_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemRead,
        output MemWrite,
        output Address,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Address,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/data_mem_periph.sv
// Data memory stage: word RAM plus a small peripheral window (timer, LEDs,
// 7-segment drive, system tick) with zero-latency loads and a timer interrupt.
module data_mem_periph #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    data_mem_periph_if.slave  bus,
    output logic [7:0]        led,
    output logic [11:0]       digi,
    output logic              irq
);
    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] mem_q [MEM_WORDS];

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;

    logic          ram_hit;
    logic          per_hit;
    logic [2:0]    per_off;
    logic [AW-1:0] ram_idx;
    logic [31:0]   rd_data;
    logic          per_wr;
    logic          tl_ovf;
    logic          ovf_set;
    logic          unused_addr_bits;

    // Word access only: the byte-lane bits never take part in the decode.
    assign unused_addr_bits = ^bus.Address[1:0];

    assign ram_hit = ({1'b0, bus.Address} < RAM_BYTES);
    assign per_hit = (bus.Address[31:5] == PERIPH_BASE[31:5]);
    assign per_off = bus.Address[4:2];
    assign ram_idx = bus.Address[AW+1:2];
    assign per_wr  = bus.MemWrite && per_hit;

    always_comb begin
        rd_data = 32'h0;
        if (ram_hit) begin
            rd_data = mem_q[ram_idx];
        end else if (per_hit) begin
            case (per_off)
                3'd0:    rd_data = th_q;
                3'd1:    rd_data = tl_q;
                3'd2:    rd_data = {29'h0, tcon_q};
                3'd3:    rd_data = {24'h0, led_q};
                3'd4:    rd_data = {20'h0, digi_q};
                3'd5:    rd_data = systick_q;
                default: rd_data = 32'h0;
            endcase
        end
        bus.ReadData = bus.MemRead ? rd_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit) begin
            mem_q[ram_idx] <= bus.WriteData;
        end
    end

    assign tl_ovf  = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    assign ovf_set = tl_ovf && tcon_q[1];

    // Timer update first, then CPU writes override; TCON[2] ORs in a same-cycle overflow
    // so a software clear can never swallow a fresh interrupt.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            tl_d = tl_ovf ? th_q : (tl_q + 32'd1);
        end
        if (ovf_set) begin
            tcon_d[2] = 1'b1;
        end

        if (per_wr) begin
            case (per_off)
                3'd0:    th_d   = bus.WriteData;
                3'd1:    tl_d   = bus.WriteData;
                3'd2:    tcon_d = {bus.WriteData[2] | ovf_set, bus.WriteData[1:0]};
                3'd3:    led_d  = bus.WriteData[7:0];
                3'd4:    digi_d = bus.WriteData[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            tcon_q    <= 3'h0;
            led_q     <= 8'h0;
            digi_q    <= 12'h0;
            systick_q <= 32'h0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = tcon_q[1] & tcon_q[2];
endmodule

// File: doc/data_mem_periph.md
Name: data_mem_periph

Overview:
- Memory stage that consumes the ALU result as a byte address (lw/sw address = rs + sign-extended offset) and the rt value as store data.
- Decodes the address into word RAM or a memory-mapped peripheral block: timer, LEDs, 7-segment drive and a free-running system tick.
- Returns load data to the write-back mux in the same cycle and raises a timer interrupt line toward the control unit.

Parameters:
- MEM_WORDS, 256, number of 32-bit RAM words; RAM occupies byte addresses 0x00000000 to MEM_WORDS*4-1.
- PERIPH_BASE, 32'h40000000, base byte address of the peripheral window (0x20 bytes).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- MemRead  input  1  load enable from controller.
- MemWrite  input  1  store enable from controller.
- Address  input  32  byte address (ALU out).
- WriteData  input  32  store data (rt).
- ReadData  output  32  load data.
- led  output  8  LED register.
- digi  output  12  7-segment register (anode select [11:8], segments [7:0]).
- irq  output  1  timer interrupt request.

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-low (reset_n).
  - On reset_n=0, these registers go to 0 immediately: TH, TL, TCON, led, digi, systick. irq=0.
  - RAM contents are not reset.
- Address decode:
  - Address[1:0] is ignored (word access only).
  - RAM hit: Address < MEM_WORDS*4; word index = Address[31:2].
  - Peripheral hit: Address[31:5] == PERIPH_BASE[31:5]. Register offsets:
    - 0x00 TH: reload value, R/W.
    - 0x04 TL: count, R/W.
    - 0x08 TCON: bits [2:0], R/W; upper bits read 0. Bit0 = enable, bit1 = irq enable, bit2 = irq status.
    - 0x0C led: bits [7:0], R/W.
    - 0x10 digi: bits [11:0], R/W.
    - 0x14 systick: read-only; writes ignored.
    - 0x18 and 0x1C: unmapped; read 0, writes ignored.
  - Any other address: reads return 0, writes are ignored.
- Reads:
  - Combinational, zero latency: ReadData = selected data when MemRead=1, else 32'h0.
  - A read in the same cycle as a write to the same location returns the old value.
- Writes:
  - Take effect on the rising clk edge when MemWrite=1.
  - MemRead and MemWrite both high: the read returns the old value and the write still occurs.
- systick:
  - Increments by 1 every cycle.
  - Wraps from 32'hFFFFFFFF to 0.
- Timer, each cycle with TCON[0]=1:
  - If TL == 32'hFFFFFFFF: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - Otherwise: TL <= TL + 1.
  - With TCON[0]=0, TL holds.
- Simultaneous events:
  - CPU write to TL or TH in the same cycle as a timer update: the CPU write to TL wins over both increment and reload. A reload in that cycle uses the old TH.
  - CPU write to TCON in the same cycle as an overflow setting bit 2: bits [1:0] take the written value, and bit2 = WriteData[2] OR overflow-set. Interrupt status is never lost.
- irq = TCON[1] & TCON[2], driven from registers, with no combinational path from the inputs.
- Clearing: software clears irq by writing TCON with bit2=0 when no overflow occurs in that cycle.
- Reset mid-count: the timer stops at once and all peripheral state is 0. The first edge after release resumes from the reset values.

Test Plan:
- RAM round trip: sw WriteData=32'hDEADBEEF at Address=32'h00000010. Next cycle, lw at 32'h00000012 -> ReadData=32'hDEADBEEF (low bits ignored). MemRead=0 -> ReadData=0.
- Out of range: write 32'h1234 to 32'h00000400 (MEM_WORDS=256) -> ignored; a read there returns 0. Word 0 is unchanged.
- Timer reload: TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011.
  - After 2 cycles: TL=32'hFFFFFFFC, TCON[2]=1, irq=1 on the cycle after the overflow edge.
  - Write TCON=3'b011 -> irq=0.
- Overflow/clear collision: write TCON=3'b011 on the exact overflow cycle -> TCON reads 3'b111 and irq stays 1.
- Peripherals: write led=32'h000000A5 and digi=32'h00000F3F -> led=8'hA5, digi=12'hF3F. Write to systick has no effect; successive systick reads differ by the elapsed cycle count.
- Async reset: assert reset_n=0 mid-count, off-edge -> led, digi, TL, TCON and irq are 0 before the next clk edge. RAM word written earlier is still readable after release.
